// File: rtl/base2_k_combiner.sv
// FP16 ldexp stage: rebuilds y = p * 2^k from the exp2 range-reduction outputs.
// Three register stages (decode, rescale, round/pack) plus saturating event counters.
module base2_k_combiner #(
    parameter int DW    = 16,
    parameter int KW    = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 valid_i,
    input  logic signed [KW-1:0] k_i,
    input  logic [DW-1:0]        p_i,
    input  logic                 clr_i,
    output logic [DW-1:0]        y_o,
    output logic                 ovf_o,
    output logic                 unf_o,
    output logic                 valid_o,
    output logic [CNT_W-1:0]     ovf_cnt_o,
    output logic [CNT_W-1:0]     unf_cnt_o
);

    localparam int EW = KW + 2;
    localparam logic signed [EW-1:0] E_MAXN  = EW'(30);
    localparam logic signed [EW-1:0] E_ONE   = EW'(1);
    localparam logic signed [EW-1:0] E_FLUSH = -EW'(11);

    typedef enum logic [2:0] {CL_ZERO, CL_SUB, CL_NORM, CL_INF, CL_NAN} cls_t;
    typedef enum logic [2:0] {K_NAN, K_INF, K_ZERO, K_OVF, K_NORM, K_SUB} kind_t;

    logic [4:0]           w_e;
    logic [9:0]           w_m;
    logic [3:0]           w_lz;
    cls_t                 w_cls;
    logic signed [EW-1:0] w_exp;
    logic [10:0]          w_man;

    logic                 r1_valid;
    logic                 r1_sign;
    logic signed [EW-1:0] r1_exp;
    logic [10:0]          r1_man;
    cls_t                 r1_cls;
    logic signed [KW-1:0] r1_k;

    assign w_e = p_i[14:10];
    assign w_m = p_i[9:0];

    // Subnormals are normalized here so the rescale stage sees one format.
    always_comb begin
        w_lz = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (w_m[i]) w_lz = 4'(10 - i);
        end
        w_cls = CL_NORM;
        w_exp = EW'(w_e);
        w_man = {1'b1, w_m};
        if (w_e == 5'd0) begin
            if (w_m == '0) begin
                w_cls = CL_ZERO;
                w_exp = '0;
                w_man = '0;
            end else begin
                w_cls = CL_SUB;
                w_man = {1'b0, w_m} << w_lz;
                w_exp = E_ONE - EW'(w_lz);
            end
        end else if (w_e == 5'h1F) begin
            w_cls = (w_m == '0) ? CL_INF : CL_NAN;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_exp   <= '0;
            r1_man   <= '0;
            r1_cls   <= CL_ZERO;
            r1_k     <= '0;
        end else begin
            r1_valid <= valid_i;
            r1_sign  <= p_i[15];
            r1_exp   <= w_exp;
            r1_man   <= w_man;
            r1_cls   <= w_cls;
            r1_k     <= k_i;
        end
    end

    logic signed [EW-1:0] w_enew;
    logic [3:0]           w_shm1;
    logic [21:0]          w_ext;
    kind_t                w_kind;
    logic [4:0]           w_exp5;
    logic [9:0]           w_frac;
    logic                 w_g;
    logic                 w_st;

    logic                 r2_valid;
    logic                 r2_sign;
    kind_t                r2_kind;
    logic [4:0]           r2_exp;
    logic [9:0]           r2_frac;
    logic                 r2_guard;
    logic                 r2_sticky;

    assign w_enew = r1_exp + EW'(r1_k);
    // Shifting by (sh-1) from an 11-bit-padded word leaves result, guard and sticky in fixed fields.
    assign w_shm1 = 4'(-w_enew);
    assign w_ext  = {r1_man, 11'b0} >> w_shm1;

    always_comb begin
        w_kind = K_ZERO;
        w_exp5 = w_enew[4:0];
        w_frac = r1_man[9:0];
        w_g    = 1'b0;
        w_st   = 1'b0;
        case (r1_cls)
            CL_NAN:  w_kind = K_NAN;
            CL_INF:  w_kind = K_INF;
            CL_ZERO: w_kind = K_ZERO;
            default: begin
                if (w_enew > E_MAXN) begin
                    w_kind = K_OVF;
                end else if (w_enew >= E_ONE) begin
                    w_kind = K_NORM;
                end else begin
                    w_kind = K_SUB;
                    if (w_enew > E_FLUSH) begin
                        w_frac = w_ext[21:12];
                        w_g    = w_ext[11];
                        w_st   = |w_ext[10:0];
                    end else begin
                        w_frac = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r2_valid  <= 1'b0;
            r2_sign   <= 1'b0;
            r2_kind   <= K_ZERO;
            r2_exp    <= '0;
            r2_frac   <= '0;
            r2_guard  <= 1'b0;
            r2_sticky <= 1'b0;
        end else begin
            r2_valid  <= r1_valid;
            r2_sign   <= r1_sign;
            r2_kind   <= w_kind;
            r2_exp    <= w_exp5;
            r2_frac   <= w_frac;
            r2_guard  <= w_g;
            r2_sticky <= w_st;
        end
    end

    logic          w_up;
    logic [14:0]   w_mag;
    logic [DW-1:0] w_y;
    logic          w_ovf;
    logic          w_unf;

    // A round-up carry out of 0x3FF lands in the exponent field, giving the smallest normal.
    assign w_up  = r2_guard & (r2_sticky | r2_frac[0]);
    assign w_mag = {5'b0, r2_frac} + {14'b0, w_up};

    always_comb begin
        w_y   = {r2_sign, 15'h0000};
        w_ovf = 1'b0;
        w_unf = 1'b0;
        case (r2_kind)
            K_NAN:  w_y = 16'h7E00;
            K_INF:  w_y = {r2_sign, 15'h7C00};
            K_ZERO: w_y = {r2_sign, 15'h0000};
            K_OVF: begin
                w_y   = {r2_sign, 15'h7C00};
                w_ovf = 1'b1;
            end
            K_NORM: w_y = {r2_sign, r2_exp, r2_frac};
            K_SUB: begin
                w_y   = {r2_sign, w_mag};
                w_unf = 1'b1;
            end
            default: w_y = {r2_sign, 15'h0000};
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_o <= 1'b0;
            y_o     <= '0;
            ovf_o   <= 1'b0;
            unf_o   <= 1'b0;
        end else begin
            valid_o <= r2_valid;
            if (r2_valid) begin
                y_o   <= w_y;
                ovf_o <= w_ovf;
                unf_o <= w_unf;
            end
        end
    end

    // Counters sample the registered flags; a clear in the same cycle discards that event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_cnt_o <= '0;
            unf_cnt_o <= '0;
        end else if (clr_i) begin
            ovf_cnt_o <= '0;
            unf_cnt_o <= '0;
        end else begin
            if (valid_o && ovf_o && !(&ovf_cnt_o)) ovf_cnt_o <= ovf_cnt_o + CNT_W'(1);
            if (valid_o && unf_o && !(&unf_cnt_o)) unf_cnt_o <= unf_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_base2_k_combiner.sv
// Bench for base2_k_combiner: vector table, random stream against an integer ldexp model,
// reset-in-flight, counter saturation and clear priority.
module tb_base2_k_combiner;

    logic              clk = 1'b0;
    logic              rstn;
    logic              valid_i = 1'b0;
    logic signed [7:0] k_i = '0;
    logic [15:0]       p_i = '0;
    logic              clr_i = 1'b0;
    logic [15:0]       y_o;
    logic              ovf_o;
    logic              unf_o;
    logic              valid_o;
    logic [15:0]       ovf_cnt_o;
    logic [15:0]       unf_cnt_o;

    base2_k_combiner #(.DW(16), .KW(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .valid_i   (valid_i),
        .k_i       (k_i),
        .p_i       (p_i),
        .clr_i     (clr_i),
        .y_o       (y_o),
        .ovf_o     (ovf_o),
        .unf_o     (unf_o),
        .valid_o   (valid_o),
        .ovf_cnt_o (ovf_cnt_o),
        .unf_cnt_o (unf_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [15:0] y;
        logic        ovf;
        logic        unf;
        int          due;
    } exp_t;

    typedef struct {
        logic [15:0]       p;
        logic signed [7:0] k;
        logic [15:0]       y;
        logic              ovf;
        logic              unf;
    } vec_t;

    exp_t        sbq[$];
    vec_t        tbl[19];
    logic [15:0] lastY = '0;
    logic        lastOvf = 1'b0;
    logic        lastUnf = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Integer reference: value = sig * 2^e2, placed by its unbiased exponent.
    function automatic void refModel(input logic [15:0] p, input logic signed [7:0] k,
                                     output logic [15:0] y, output logic o, output logic u);
        int e, m, sig, e2, h, ub, t, d, q, rem, half, frac;
        e = int'(p[14:10]);
        m = int'(p[9:0]);
        o = 1'b0;
        u = 1'b0;
        if (e == 31) begin
            y = (m != 0) ? 16'h7E00 : {p[15], 15'h7C00};
            return;
        end
        if (e == 0 && m == 0) begin
            y = {p[15], 15'h0000};
            return;
        end
        if (e == 0) begin
            sig = m;
            e2  = -24;
        end else begin
            sig = 1024 + m;
            e2  = e - 25;
        end
        h = 0;
        for (int i = 0; i < 11; i++) if (((sig >> i) & 1) == 1) h = i;
        ub = h + e2 + k;
        if (ub >= 16) begin
            y = {p[15], 15'h7C00};
            o = 1'b1;
        end else if (ub >= -14) begin
            frac = (sig << (10 - h)) & 1023;
            y = {p[15], 5'(ub + 15), 10'(frac)};
        end else begin
            u = 1'b1;
            t = e2 + k + 24;
            if (t >= 0) begin
                q = sig << t;
            end else if (-t >= 20) begin
                q = 0;
            end else begin
                d    = -t;
                q    = sig >> d;
                rem  = sig - (q << d);
                half = 1 << (d - 1);
                if (rem > half || (rem == half && (q & 1) == 1)) q++;
            end
            y = {p[15], 15'(q)};
        end
    endfunction

    task automatic applyStimulus(input logic [15:0] p, input logic signed [7:0] k,
                                 input logic [15:0] y, input logic o, input logic u);
        exp_t ex;
        @(negedge clk);
        valid_i = 1'b1;
        p_i     = p;
        k_i     = k;
        ex.y    = y;
        ex.ovf  = o;
        ex.unf  = u;
        ex.due  = cyc + 3;
        sbq.push_back(ex);
    endtask

    task automatic applyModel(input logic [15:0] p, input logic signed [7:0] k);
        logic [15:0] y;
        logic o, u;
        refModel(p, k, y, o, u);
        applyStimulus(p, k, y, o, u);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_i = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (sbq.size() != 0 && guard < 50) begin
            @(negedge clk);
            valid_i = 1'b0;
            guard++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout: got %0d pending results required 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    // Scoreboard monitor: pops on valid_o, otherwise checks the outputs hold.
    always @(negedge clk) begin
        exp_t ex;
        if (!rstn) begin
            lastY   = '0;
            lastOvf = 1'b0;
            lastUnf = 1'b0;
        end else if (valid_o) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_valid: got valid_o=1 required 0");
            end else begin
                ex = sbq.pop_front();
                checkOutput("y_o", 32'(y_o), 32'(ex.y));
                checkOutput("ovf_o", 32'(ovf_o), 32'(ex.ovf));
                checkOutput("unf_o", 32'(unf_o), 32'(ex.unf));
                checkOutput("latency", 32'(cyc), 32'(ex.due));
            end
            lastY   = y_o;
            lastOvf = ovf_o;
            lastUnf = unf_o;
        end else begin
            checkOutput("hold_y", 32'(y_o), 32'(lastY));
            checkOutput("hold_flags", {30'b0, ovf_o, unf_o}, {30'b0, lastOvf, lastUnf});
        end
    end

    initial begin
        int w;
        tbl[0]  = '{16'h3C00,  8'sd3,   16'h4800, 1'b0, 1'b0};
        tbl[1]  = '{16'h3E00, -8'sd1,   16'h3A00, 1'b0, 1'b0};
        tbl[2]  = '{16'h3FFF,  8'sd16,  16'h7C00, 1'b1, 1'b0};
        tbl[3]  = '{16'hBC00,  8'sd16,  16'hFC00, 1'b1, 1'b0};
        tbl[4]  = '{16'h3C00,  8'sd127, 16'h7C00, 1'b1, 1'b0};
        tbl[5]  = '{16'h3E00, -8'sd16,  16'h0180, 1'b0, 1'b1};
        tbl[6]  = '{16'h3C00, -8'sd24,  16'h0001, 1'b0, 1'b1};
        tbl[7]  = '{16'h3C00, -8'sd25,  16'h0000, 1'b0, 1'b1};
        tbl[8]  = '{16'h3E00, -8'sd25,  16'h0001, 1'b0, 1'b1};
        tbl[9]  = '{16'h3FFF, -8'sd15,  16'h0400, 1'b0, 1'b1};
        tbl[10] = '{16'h3C00,  8'h80,   16'h0000, 1'b0, 1'b1};
        tbl[11] = '{16'h7E01,  8'sd0,   16'h7E00, 1'b0, 1'b0};
        tbl[12] = '{16'hFC00, -8'sd5,   16'hFC00, 1'b0, 1'b0};
        tbl[13] = '{16'h8000,  8'sd9,   16'h8000, 1'b0, 1'b0};
        tbl[14] = '{16'h0001,  8'sd24,  16'h3C00, 1'b0, 1'b0};
        tbl[15] = '{16'h8400, -8'sd20,  16'h8000, 1'b0, 1'b1};
        tbl[16] = '{16'h3C00,  8'sd15,  16'h7800, 1'b0, 1'b0};
        tbl[17] = '{16'h7C00,  8'sd100, 16'h7C00, 1'b0, 1'b0};
        tbl[18] = '{16'h0001, -8'sd3,   16'h0000, 1'b0, 1'b1};

        rstn = 1'b1;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", 32'(valid_o), 32'd0);
        checkOutput("reset_y", 32'(y_o), 32'd0);
        checkOutput("reset_flags", {30'b0, ovf_o, unf_o}, 32'd0);
        checkOutput("reset_cnts", {ovf_cnt_o, unf_cnt_o}, 32'd0);
        rstn = 1'b1;
        idle(2);

        for (int i = 0; i < 19; i++) applyStimulus(tbl[i].p, tbl[i].k, tbl[i].y, tbl[i].ovf, tbl[i].unf);
        drain("table");
        idle(2);
        checkOutput("ovf_cnt_table", 32'(ovf_cnt_o), 32'd3);
        checkOutput("unf_cnt_table", 32'(unf_cnt_o), 32'd8);

        // 20 back-to-back random samples, then sparse ones with idle gaps.
        for (int i = 0; i < 20; i++) begin
            if (i % 4 == 3) applyModel(16'($urandom), 8'($urandom));
            else applyModel(16'($urandom), 8'(int'($urandom_range(0, 50)) - 25));
        end
        for (int i = 0; i < 8; i++) begin
            applyModel(16'($urandom_range(16'h3C00, 16'h3FFF)), 8'(int'($urandom_range(0, 60)) - 40));
            idle(int'($urandom_range(1, 4)));
        end
        drain("random");
        idle(2);

        applyStimulus(16'h3C00, 8'sd127, 16'h7C00, 1'b1, 1'b0);
        applyStimulus(16'h3C00, 8'h80, 16'h0000, 1'b0, 1'b1);
        @(negedge clk);
        valid_i = 1'b0;
        rstn    = 1'b0;
        sbq.delete();
        @(negedge clk);
        checkOutput("midreset_valid", 32'(valid_o), 32'd0);
        checkOutput("midreset_y", 32'(y_o), 32'd0);
        checkOutput("midreset_cnts", {ovf_cnt_o, unf_cnt_o}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        idle(8);
        checkOutput("postreset_cnts", {ovf_cnt_o, unf_cnt_o}, 32'd0);

        for (int i = 0; i < 65537; i++) applyStimulus(16'h3C00, 8'h80, 16'h0000, 1'b0, 1'b1);
        drain("saturate");
        idle(2);
        checkOutput("unf_cnt_sat", 32'(unf_cnt_o), 32'h0000FFFF);
        checkOutput("ovf_cnt_sat", 32'(ovf_cnt_o), 32'd0);

        @(negedge clk);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        checkOutput("unf_cnt_clr", 32'(unf_cnt_o), 32'd0);

        applyStimulus(16'h3C00, 8'h80, 16'h0000, 1'b0, 1'b1);
        w = 0;
        do begin
            @(negedge clk);
            valid_i = 1'b0;
            w++;
        end while (!valid_o && w < 10);
        if (!valid_o) begin
            total++;
            bad++;
            $display("[TB] FAIL clr_event_timeout: got valid_o=0 required 1");
        end
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        checkOutput("unf_cnt_coincident_clr", 32'(unf_cnt_o), 32'd0);
        @(negedge clk);
        checkOutput("unf_cnt_after_clr", 32'(unf_cnt_o), 32'd0);

        applyStimulus(16'h3C00, 8'h80, 16'h0000, 1'b0, 1'b1);
        drain("single");
        idle(2);
        checkOutput("unf_cnt_single", 32'(unf_cnt_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
